// File: rtl/m2_sched_pkg.sv
// Shared types and helpers for the m2_sched round-robin scheduler and its
// bit-serial ones-mod-4 detector core.
package m2_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CORE_W = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/m2_core.sv
// Mealy detector: counts sampled ones modulo 4 and flags every fourth one.
// Synchronous clr wins over en; all state changes on the falling clock edge.
module m2_core
  import m2_sched_pkg::*;
(
  input  logic ck,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic a,
  output logic hit
);

  logic [CORE_W-1:0] st;

  always_ff @(negedge ck or negedge rst_n) begin
    if (!rst_n) begin
      st <= '0;
    end else if (clr) begin
      st <= '0;
    end else if (en && a) begin
      st <= st + 1'b1;
    end
  end

  // The fourth one wraps the state to 0 on the same edge it is flagged.
  assign hit = en & a & (st == {CORE_W{1'b1}});

endmodule

// File: rtl/m2_sched.sv
// Round-robin scheduler granting one serial requester at a time exclusive use
// of a single ones-mod-4 detector for a FRAME_LEN-bit frame.
module m2_sched
  import m2_sched_pkg::*;
#(
  parameter int N         = 4,
  parameter int FRAME_LEN = 8,
  parameter int CW        = 4
) (
  input  logic                ck,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        din,
  output logic [N-1:0]        gnt,
  output logic                busy,
  output logic                hit,
  output logic                done,
  output logic [clog2(N)-1:0] done_id,
  output logic [CW-1:0]       hits
);

  localparam int IW = clog2(N);
  localparam int BW = clog2(FRAME_LEN + 1);
  localparam logic [BW-1:0] LAST    = BW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] ACC_MAX = {CW{1'b1}};

  state_t        st, st_nx;
  logic [IW-1:0] ptr, sel, pick, cand;
  logic          pick_ok;
  logic [BW-1:0] cnt;
  logic [CW-1:0] acc, acc_nx;
  logic          core_hit, core_en, core_clr, sel_req, last_bit;

  assign sel_req  = req[sel];
  assign last_bit = (cnt == LAST);
  assign busy     = (st == RUN);
  assign core_en  = busy && sel_req;
  assign core_clr = !busy;
  assign hit      = busy & core_hit;
  assign acc_nx   = (acc == ACC_MAX) ? acc : acc + CW'(core_hit);

  m2_core u_core (
    .ck    (ck),
    .rst_n (rst_n),
    .clr   (core_clr),
    .en    (core_en),
    .a     (din[sel]),
    .hit   (core_hit)
  );

  // First requesting line after the pointer, wrapping, so the last winner goes last.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!pick_ok && req[cand]) begin
        pick_ok = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    st_nx = st;
    case (st)
      IDLE, DONE: st_nx = pick_ok ? RUN : IDLE;
      RUN: begin
        if (!sel_req)      st_nx = IDLE;
        else if (last_bit) st_nx = DONE;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(negedge ck or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      ptr     <= IW'(N - 1);
      sel     <= '0;
      cnt     <= '0;
      acc     <= '0;
      gnt     <= '0;
      done    <= 1'b0;
      done_id <= '0;
      hits    <= '0;
    end else begin
      st   <= st_nx;
      done <= 1'b0;
      case (st)
        RUN: begin
          // A dropped request abandons the frame silently; the pointer keeps sel.
          if (!sel_req) begin
            gnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            acc <= acc_nx;
            if (last_bit) begin
              hits    <= acc_nx;
              done_id <= sel;
              done    <= 1'b1;
              gnt     <= '0;
            end
          end
        end
        default: begin
          if (pick_ok) begin
            gnt <= N'(1) << pick;
            ptr <= pick;
            sel <= pick;
            cnt <= '0;
            acc <= '0;
          end else begin
            gnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m2_sched.sv
// Randomized and directed bench for m2_sched against a frame-level model:
// round-robin order, hits = ones/4 (saturating), hit on every fourth one.
module tb_m2_sched;
  import m2_sched_pkg::*;

  localparam int N  = 4;
  localparam int FL = 8;
  localparam int CW = 4;

  logic          ck = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  din = '0;
  logic [N-1:0]  gnt, gnt_s;
  logic          busy, hit, done, busy_s, hit_s, done_s;
  logic [1:0]    done_id, done_id_s;
  logic [CW-1:0] hits;
  logic [0:0]    hits_s;

  int total = 0;
  int bad   = 0;

  // Model state
  int ptr_m, exp_id, exp_hits;

  // Observations captured by play_frame
  logic [N-1:0]  o_gnt, o_gnt_after;
  logic          o_busy, o_busy_after, o_done;
  logic [FL-1:0] o_mask;
  logic [1:0]    o_id;
  logic [CW-1:0] o_hits;
  logic [0:0]    o_hits_s;

  m2_sched #(.N(N), .FRAME_LEN(FL), .CW(CW)) dut (
    .ck(ck), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt), .busy(busy),
    .hit(hit), .done(done), .done_id(done_id), .hits(hits)
  );

  m2_sched #(.N(N), .FRAME_LEN(FL), .CW(1)) dut_sat (
    .ck(ck), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt_s), .busy(busy_s),
    .hit(hit_s), .done(done_s), .done_id(done_id_s), .hits(hits_s)
  );

  always #5 ck = ~ck;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic int rr_next(input int p, input logic [N-1:0] r);
    for (int i = 1; i <= N; i++)
      if (((r >> ((p + i) % N)) & 1) != 0) return (p + i) % N;
    return 0;
  endfunction

  function automatic int hits_of(input logic [FL-1:0] b, input int w);
    int v, mx;
    v  = $countones(b) / 4;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [FL-1:0] mask_of(input logic [FL-1:0] b);
    int ones;
    logic [FL-1:0] m;
    ones = 0;
    m = '0;
    for (int k = 0; k < FL; k++)
      if (((b >> k) & 1) != 0) begin
        ones++;
        if (ones % 4 == 0) m = m | (FL'(1) << k);
      end
    return m;
  endfunction

  // Drives one full frame starting just after a rising edge; every line gets the same bit.
  task automatic play_frame(input logic [N-1:0] r, input logic [FL-1:0] bits);
    req = r;
    din = '0;
    @(negedge ck); @(posedge ck);
    o_gnt  = gnt;
    o_busy = busy;
    o_mask = '0;
    for (int b = 0; b < FL; b++) begin
      din = (((bits >> b) & 1) != 0) ? '1 : '0;
      #1 o_mask = o_mask | (FL'(hit) << b);
      @(negedge ck); @(posedge ck);
    end
    din          = '0;
    o_done       = done;
    o_id         = done_id;
    o_hits       = hits;
    o_hits_s     = hits_s;
    o_gnt_after  = gnt;
    o_busy_after = busy;
  endtask

  task automatic test_reset();
    din = '1;
    #12;
    total++; if (gnt !== '0)     begin bad++; $display("[TB] FAIL rst_gnt: got %b want 0", gnt); end
    total++; if (busy !== 1'b0)  begin bad++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("[TB] FAIL rst_done: got %b want 0", done); end
    total++; if (done_id !== '0) begin bad++; $display("[TB] FAIL rst_id: got %0d want 0", done_id); end
    total++; if (hits !== '0)    begin bad++; $display("[TB] FAIL rst_hits: got %0d want 0", hits); end
    total++; if (hit !== 1'b0)   begin bad++; $display("[TB] FAIL rst_hit: got %b want 0", hit); end
    @(posedge ck);
    din   = '0;
    rst_n = 1'b1;
    ptr_m = N - 1;
    exp_id = 0;
    exp_hits = 0;
  endtask

  task automatic test_round_robin();
    int g;
    for (int f = 0; f < 5; f++) begin
      g = rr_next(ptr_m, 4'b1111);
      play_frame(4'b1111, '0);
      total++; if (o_gnt !== N'(1) << g) begin bad++; $display("[TB] FAIL rr_gnt[%0d]: got %b want %b", f, o_gnt, N'(1) << g); end
      total++; if (o_id !== 2'(g))       begin bad++; $display("[TB] FAIL rr_id[%0d]: got %0d want %0d", f, o_id, g); end
      total++; if (o_hits !== '0)        begin bad++; $display("[TB] FAIL rr_hits[%0d]: got %0d want 0", f, o_hits); end
      total++; if (o_done !== 1'b1 || o_gnt_after !== '0)
        begin bad++; $display("[TB] FAIL rr_end[%0d]: got done=%b gnt=%b want done=1 gnt=0", f, o_done, o_gnt_after); end
      ptr_m = g;
      exp_id = g;
      exp_hits = 0;
    end
  endtask

  task automatic test_directed();
    logic [N-1:0]  rv [3] = '{4'b0001, 4'b0001, 4'b0010};
    logic [FL-1:0] bv [3] = '{8'hFF, 8'hCD, 8'hFF};
    int g;
    for (int k = 0; k < 3; k++) begin
      g = rr_next(ptr_m, rv[k]);
      play_frame(rv[k], bv[k]);
      total++; if (o_gnt !== N'(1) << g) begin bad++; $display("[TB] FAIL dir_gnt[%0d]: got %b want %b", k, o_gnt, N'(1) << g); end
      total++; if (o_busy !== 1'b1)      begin bad++; $display("[TB] FAIL dir_busy[%0d]: got %b want 1", k, o_busy); end
      total++; if (o_mask !== mask_of(bv[k])) begin bad++; $display("[TB] FAIL dir_hitmask[%0d]: got %b want %b", k, o_mask, mask_of(bv[k])); end
      total++; if (o_done !== 1'b1)      begin bad++; $display("[TB] FAIL dir_done[%0d]: got %b want 1", k, o_done); end
      total++; if (o_id !== 2'(g))       begin bad++; $display("[TB] FAIL dir_id[%0d]: got %0d want %0d", k, o_id, g); end
      total++; if (o_hits !== CW'(hits_of(bv[k], CW))) begin bad++; $display("[TB] FAIL dir_hits[%0d]: got %0d want %0d", k, o_hits, hits_of(bv[k], CW)); end
      total++; if (o_hits_s !== 1'(hits_of(bv[k], 1))) begin bad++; $display("[TB] FAIL dir_sat[%0d]: got %0d want %0d", k, o_hits_s, hits_of(bv[k], 1)); end
      total++; if (o_busy_after !== 1'b0) begin bad++; $display("[TB] FAIL dir_busy_end[%0d]: got %b want 0", k, o_busy_after); end
      ptr_m = g;
      exp_id = g;
      exp_hits = hits_of(bv[k], CW);
    end
  endtask

  task automatic test_abort();
    int g, g2;
    g = rr_next(ptr_m, 4'b1111);
    req = 4'b1111;
    din = '1;
    @(negedge ck); @(posedge ck);
    total++; if (gnt !== N'(1) << g) begin bad++; $display("[TB] FAIL ab_gnt: got %b want %b", gnt, N'(1) << g); end
    repeat (3) begin @(negedge ck); @(posedge ck); end
    req = 4'b1111 & ~(N'(1) << g);
    @(negedge ck); @(posedge ck);
    total++; if (gnt !== '0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL ab_stop: got gnt=%b busy=%b want 0 0", gnt, busy); end
    total++; if (done !== 1'b0)           begin bad++; $display("[TB] FAIL ab_done: got %b want 0", done); end
    total++; if (done_id !== 2'(exp_id))  begin bad++; $display("[TB] FAIL ab_id: got %0d want %0d", done_id, exp_id); end
    total++; if (hits !== CW'(exp_hits))  begin bad++; $display("[TB] FAIL ab_hits: got %0d want %0d", hits, exp_hits); end
    ptr_m = g;
    g2 = rr_next(ptr_m, req);
    @(negedge ck); @(posedge ck);
    total++; if (gnt !== N'(1) << g2) begin bad++; $display("[TB] FAIL ab_next: got %b want %b", gnt, N'(1) << g2); end
    req = '0;
    din = '0;
    @(negedge ck); @(posedge ck);
    ptr_m = g2;
  endtask

  task automatic test_random();
    logic [N-1:0]  r;
    logic [FL-1:0] b;
    int g, want;
    for (int k = 0; k < 24; k++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      b = FL'($urandom);
      g = rr_next(ptr_m, r);
      want = hits_of(b, CW);
      play_frame(r, b);
      total++; if (o_gnt !== N'(1) << g)  begin bad++; $display("[TB] FAIL rnd_gnt[%0d]: got %b want %b", k, o_gnt, N'(1) << g); end
      total++; if (o_mask !== mask_of(b)) begin bad++; $display("[TB] FAIL rnd_hitmask[%0d]: got %b want %b", k, o_mask, mask_of(b)); end
      total++; if (o_done !== 1'b1 || o_id !== 2'(g)) begin bad++; $display("[TB] FAIL rnd_done[%0d]: got done=%b id=%0d want 1 %0d", k, o_done, o_id, g); end
      total++; if (o_hits !== CW'(want))  begin bad++; $display("[TB] FAIL rnd_hits[%0d]: got %0d want %0d", k, o_hits, want); end
      total++; if (o_hits_s !== 1'(hits_of(b, 1))) begin bad++; $display("[TB] FAIL rnd_sat[%0d]: got %0d want %0d", k, o_hits_s, hits_of(b, 1)); end
      ptr_m = g;
      exp_id = g;
      exp_hits = want;
    end
    req = '0;
    @(negedge ck); @(posedge ck);
  endtask

  task automatic test_reset_midframe();
    int g;
    play_frame(4'b0100, 8'hFF);
    total++; if (o_id !== 2'd2 || o_hits !== CW'(2)) begin bad++; $display("[TB] FAIL mid_pre: got id=%0d hits=%0d want 2 2", o_id, o_hits); end
    req = 4'b1111;
    din = '1;
    @(negedge ck); @(posedge ck);
    repeat (4) begin @(negedge ck); @(posedge ck); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (gnt !== '0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_ctl: got gnt=%b busy=%b want 0 0", gnt, busy); end
    total++; if (hits !== '0 || done_id !== '0) begin bad++; $display("[TB] FAIL mid_rst_res: got hits=%0d id=%0d want 0 0", hits, done_id); end
    total++; if (hits_s !== '0) begin bad++; $display("[TB] FAIL mid_rst_sat: got %0d want 0", hits_s); end
    @(posedge ck);
    rst_n = 1'b1;
    ptr_m = N - 1;
    g = rr_next(ptr_m, req);
    @(negedge ck); @(posedge ck);
    total++; if (gnt !== N'(1) << g) begin bad++; $display("[TB] FAIL mid_first: got %b want %b", gnt, N'(1) << g); end
    req = '0;
    din = '0;
    @(negedge ck); @(posedge ck);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_directed();
    test_abort();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
